// File: rtl/qpsk_framer.sv
// Frame builder ahead of the QPSK mapper: alternating preamble, sync word, then
// payload bytes (optionally scrambled), serialised as {i,q} dibits on valid/ready.
module qpsk_framer #(
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [31:0] SYNC_WORD    = 32'h1ACFFC1D,
    parameter bit          SCRAMBLE     = 1'b1,
    parameter logic [6:0]  LFSR_SEED    = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_i,
    output logic       out_q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    // One counter serves both preamble and the 16-dibit sync word.
    localparam int CW = $clog2((PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16);

    typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, PAYLOAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      lfsr_q, lfsr_d;
    logic [7:0]      buf_q, buf_d;
    logic            buf_vld_q, buf_vld_d;
    logic            last_q, last_d;
    logic [1:0]      idx_q, idx_d;
    logic            out_i_q, out_i_d;
    logic            out_q_q, out_q_d;
    logic            out_valid_q, out_valid_d;

    logic            load;
    logic            accept;
    logic            in_ready_c;
    logic [31:0]     sync_sh;
    logic [7:0]      byte_sh;
    logic [6:0]      s1, s2;

    always_comb begin
        load    = !out_valid_q || out_ready;
        // The buffer is filled as soon as the frame starts so the first payload
        // dibit follows the sync word without a bubble.
        in_ready_c = (state_q != IDLE) &&
                     (!buf_vld_q ||
                      (state_q == PAYLOAD && idx_q == 2'd3 && load && !last_q));
        accept  = in_valid && in_ready_c;
        sync_sh = SYNC_WORD << {cnt_q[3:0], 1'b0};
        byte_sh = buf_q << {idx_q, 1'b0};
        s1      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[3]};
        s2      = {s1[5:0], s1[6] ^ s1[3]};

        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        buf_d       = buf_q;
        buf_vld_d   = buf_vld_q;
        last_d      = last_q;
        idx_d       = idx_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;

        if (load) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = PREAMBLE;
                    lfsr_d  = LFSR_SEED;
                    cnt_d   = '0;
                end
            end
            PREAMBLE: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_i_d     = cnt_q[0];
                    out_q_d     = cnt_q[0];
                    if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = SYNC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SYNC: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_i_d     = sync_sh[31];
                    out_q_d     = sync_sh[30];
                    if (cnt_q == CW'(15)) begin
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAYLOAD: begin
                if (load && buf_vld_q) begin
                    out_valid_d = 1'b1;
                    if (SCRAMBLE) begin
                        out_i_d = byte_sh[7] ^ lfsr_q[6];
                        out_q_d = byte_sh[6] ^ s1[6];
                        lfsr_d  = s2;
                    end else begin
                        out_i_d = byte_sh[7];
                        out_q_d = byte_sh[6];
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        buf_vld_d = 1'b0;
                        if (last_q) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            buf_d     = in_data;
            buf_vld_d = 1'b1;
            last_d    = in_last;
            idx_d     = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            buf_q       <= '0;
            buf_vld_q   <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            out_i_q     <= 1'b0;
            out_q_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qpsk_framer.sv
// Directed bench for qpsk_framer: plain and scrambled instances, backpressure,
// back-to-back bytes, input starvation and mid-frame reset.
module tb_qpsk_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_data0 = '0, in_data1 = '0;
    logic in_valid0 = 0, in_last0 = 0, out_ready0 = 1;
    logic in_valid1 = 0, in_last1 = 0, out_ready1 = 1;
    logic in_ready0, out_i0, out_q0, out_valid0, busy0;
    logic in_ready1, out_i1, out_q1, out_valid1, busy1;

    qpsk_framer #(.PREAMBLE_LEN(4), .SCRAMBLE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
        .in_last(in_last0), .in_ready(in_ready0), .out_i(out_i0), .out_q(out_q0),
        .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0));

    qpsk_framer #(.PREAMBLE_LEN(4), .SCRAMBLE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_last(in_last1), .in_ready(in_ready1), .out_i(out_i1), .out_q(out_q1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1));

    int n_assert = 0, n_fail = 0;
    bit stall = 0;

    // Monitor: samples on the falling edge, when inputs and registered outputs are stable.
    logic [1:0] q0[$], q1[$];
    int hs0[$];
    int cyc = 0, run0 = 0, max_run0 = 0, epoch = 0, seen_epoch = 0, stall_err = 0;
    logic pv = 0, pr = 0, pi = 0, pq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid0 && out_ready0) q0.push_back({out_i0, out_q0});
        if (out_valid1 && out_ready1) q1.push_back({out_i1, out_q1});
        if (in_valid0 && in_ready0) hs0.push_back(cyc);
        if (epoch != seen_epoch) begin
            seen_epoch <= epoch;
            run0       <= out_valid0 ? 1 : 0;
            max_run0   <= out_valid0 ? 1 : 0;
        end else begin
            run0 <= out_valid0 ? run0 + 1 : 0;
            if (out_valid0 && run0 + 1 > max_run0) max_run0 <= run0 + 1;
        end
        if (rst_n && pv && !pr && (!out_valid0 || out_i0 !== pi || out_q0 !== pq))
            stall_err <= stall_err + 1;
        pv <= out_valid0; pr <= out_ready0; pi <= out_i0; pq <= out_q0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        out_ready0 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send0(input logic [7:0] b, input logic last, input bit keep);
        bit ok = 0;
        in_data0 = b; in_last0 = last; in_valid0 = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (in_ready0) ok = 1;
            tick();
        end
        if (!ok) chk("send0_timeout", 0, 1);
        if (!keep) in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b, input logic last);
        bit ok = 0;
        in_data1 = b; in_last1 = last; in_valid1 = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (in_ready1) ok = 1;
            tick();
        end
        if (!ok) chk("send1_timeout", 0, 1);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            if (!busy0 && !out_valid0 && !busy1 && !out_valid1) done = 1;
            else tick();
        end
        if (!done) chk(tag, 0, 1);
    endtask

    // Expected dibit stream, built from hand-decoded constants.
    int exp_q[$];
    int sync_d[16] = '{0,1,2,2,3,0,3,3,3,3,3,0,0,1,3,1};

    function automatic void add_hdr();
        for (int k = 0; k < 4; k++) exp_q.push_back((k % 2) ? 3 : 0);
        for (int k = 0; k < 16; k++) exp_q.push_back(sync_d[k]);
    endfunction

    function automatic void add_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) exp_q.push_back(int'((b >> (6 - 2 * k)) & 8'h3));
    endfunction

    task automatic check_seq0(input string tag, input int base);
        chk({tag, "_count"}, q0.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < q0.size()) chk(tag, q0[base + k], exp_q[k]);
        exp_q.delete();
    endtask

    initial begin
        int base, hb;
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_i", out_i0, 0);
        chk("rst_out_q", out_q0, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_busy", busy0, 0);
        #20 rst_n = 1'b1;
        tick(); tick();

        // Single unscrambled byte frame
        epoch++; base = q0.size();
        send0(8'hB4, 1'b1, 0);
        wait_idle("t1_idle_timeout");
        add_hdr(); add_byte(8'hB4);
        check_seq0("t1_dibit", base);
        chk("t1_contig", max_run0, 24);
        chk("t1_busy_after", busy0, 0);

        // Scrambled single-byte frames, reseed on each frame
        for (int f = 0; f < 2; f++) begin
            base = q1.size();
            send1(8'h00, 1'b1);
            wait_idle("t2_idle_timeout");
            chk("t2_count", q1.size() - base, 24);
            if (q1.size() >= base + 24) begin
                chk("t2_pay0", q1[base + 20], 3);
                chk("t2_pay1", q1[base + 21], 3);
                chk("t2_pay2", q1[base + 22], 3);
                chk("t2_pay3", q1[base + 23], 2);
            end
        end

        // Back-to-back bytes with in_valid held high
        epoch++; base = q0.size(); hb = hs0.size();
        send0(8'hA5, 1'b0, 1);
        send0(8'h3C, 1'b0, 1);
        send0(8'h0F, 1'b0, 1);
        send0(8'hF0, 1'b1, 0);
        wait_idle("t4_idle_timeout");
        add_hdr(); add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h0F); add_byte(8'hF0);
        check_seq0("t4_dibit", base);
        chk("t4_contig", max_run0, 36);
        if (hs0.size() >= hb + 4) begin
            chk("t4_ready_gap1", hs0[hb + 2] - hs0[hb + 1], 4);
            chk("t4_ready_gap2", hs0[hb + 3] - hs0[hb + 2], 4);
        end else chk("t4_handshakes", hs0.size() - hb, 4);

        // Random backpressure on a 3-byte frame
        stall = 1; base = q0.size();
        send0(8'hA5, 1'b0, 1);
        send0(8'h3C, 1'b0, 1);
        send0(8'h0F, 1'b1, 0);
        wait_idle("t3_idle_timeout");
        stall = 0; tick();
        add_hdr(); add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h0F);
        check_seq0("t3_dibit", base);
        chk("t3_stall_stable", stall_err, 0);

        // Input starvation between bytes
        epoch++; base = q0.size();
        send0(8'h96, 1'b0, 0);
        for (int k = 0; k < 300 && q0.size() < base + 24; k++) tick();
        repeat (5) tick();
        chk("t5_gap_valid", out_valid0, 0);
        chk("t5_gap_busy", busy0, 1);
        send0(8'h69, 1'b1, 0);
        wait_idle("t5_idle_timeout");
        add_hdr(); add_byte(8'h96); add_byte(8'h69);
        check_seq0("t5_dibit", base);
        chk("t5_run", max_run0, 24);

        // Reset asserted mid-SYNC
        base = q0.size();
        send0(8'hB4, 1'b1, 0);
        for (int k = 0; k < 300 && q0.size() < base + 6; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid0, 0);
        chk("t6_rst_busy", busy0, 0);
        chk("t6_rst_in_ready", in_ready0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_idle_valid", out_valid0, 0);
        base = q0.size();
        send0(8'hB4, 1'b1, 0);
        wait_idle("t6_idle_timeout");
        add_hdr(); add_byte(8'hB4);
        check_seq0("t6_dibit", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
